rv_elastic_buffer: RTL and testbench

RV_ELASTIC_BUFFER -- requirements
Module: rv_elastic_buffer

---
 rtl/rv_elastic_buffer.sv | 79 +++++++
 tb/tb_rv_elastic_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rv_elastic_buffer.sv
// Ready/valid elastic buffer: DEPTH-entry circular FIFO with registered-only ready/valid,
// synchronous flush and asynchronous active-high reset.
module rv_elastic_buffer #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             in_fire,
  output logic             out_fire
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty, full;

  // Occupancy (EMPTY / PARTIAL / FULL) is derived purely from count_q.
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = count_q;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  // Gating by reset keeps in_fire low while in_ready reads 1 during reset.
  assign in_fire  = in_valid && in_ready && !flush && !reset;
  assign out_fire = out_valid && out_ready && !flush && !reset;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (in_fire)  wr_ptr_d = wr_ptr_q + PW'(1);
      if (out_fire) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({in_fire, out_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; out_data is masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (in_fire) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_rv_elastic_buffer.sv
// Directed bench for rv_elastic_buffer (WIDTH=16, DEPTH=4): inputs change on the falling
// edge, outputs are sampled 1 ns later, state advances on the rising edge.
module tb_rv_elastic_buffer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             in_fire;
  logic             out_fire;

  int n_checks = 0;
  int n_pass   = 0;

  rv_elastic_buffer #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count),
    .in_fire  (in_fire),
    .out_fire (out_fire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hDEAD;
    out_ready = 1'b1;

    // Held in reset across a rising edge, with traffic offered.
    @(negedge clk);
    #1;
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_in_fire", 32'(in_fire), 32'd0);
    check_eq("rst_out_fire", 32'(out_fire), 32'd0);

    // Fill with out_ready low: A..D accepted, E held off.
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(16'hA + i);
      #1;
      check_eq($sformatf("fill_in_ready_%0d", i), 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
      check_eq($sformatf("fill_in_fire_%0d", i), 32'(in_fire), (i < 4) ? 32'd1 : 32'd0);
      check_eq($sformatf("fill_count_%0d", i), 32'(count), 32'(i < 4 ? i : 4));
      @(negedge clk);
    end
    #1;
    check_eq("full_count", 32'(count), 32'd4);
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    check_eq("full_head", 32'(out_data), 32'hA);

    // Drain with E still offered: A,B,C,D,E in order; E enters after the first pop.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i <= 1);
      #1;
      check_eq($sformatf("drain_valid_%0d", i), 32'(out_valid), 32'd1);
      check_eq($sformatf("drain_data_%0d", i), 32'(out_data), 32'hA + 32'(i));
      check_eq($sformatf("drain_out_fire_%0d", i), 32'(out_fire), 32'd1);
      if (i <= 1) check_eq($sformatf("drain_in_fire_%0d", i), 32'(in_fire), 32'(i));
      @(negedge clk);
    end
    #1;
    check_eq("drained_valid", 32'(out_valid), 32'd0);
    check_eq("drained_data", 32'(out_data), 32'd0);
    check_eq("drained_count", 32'(count), 32'd0);
    @(negedge clk);

    // Single push into empty buffer with out_ready high: no pass-through, visible next cycle.
    in_valid = 1'b1;
    in_data  = 16'h1234;
    #1;
    check_eq("lat_t_out_valid", 32'(out_valid), 32'd0);
    check_eq("lat_t_out_fire", 32'(out_fire), 32'd0);
    check_eq("lat_t_in_fire", 32'(in_fire), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_eq("lat_t1_valid", 32'(out_valid), 32'd1);
    check_eq("lat_t1_data", 32'(out_data), 32'h1234);
    check_eq("lat_t1_count", 32'(count), 32'd1);
    check_eq("lat_t1_out_fire", 32'(out_fire), 32'd1);
    @(negedge clk);
    #1;
    check_eq("lat_t2_count", 32'(count), 32'd0);
    check_eq("lat_t2_valid", 32'(out_valid), 32'd0);
    @(negedge clk);

    // Streaming 20 words: one push and one pop per cycle, count steady at 1, wraps several times.
    for (int i = 0; i <= 20; i++) begin
      in_valid = (i < 20);
      in_data  = WIDTH'(16'h100 + i);
      #1;
      if (i < 20) check_eq($sformatf("strm_in_fire_%0d", i), 32'(in_fire), 32'd1);
      check_eq($sformatf("strm_count_%0d", i), 32'(count), (i == 0) ? 32'd0 : 32'd1);
      if (i > 0) begin
        check_eq($sformatf("strm_out_fire_%0d", i), 32'(out_fire), 32'd1);
        check_eq($sformatf("strm_data_%0d", i), 32'(out_data), 32'h100 + 32'(i - 1));
      end
      @(negedge clk);
    end
    #1;
    check_eq("strm_end_count", 32'(count), 32'd0);

    // Flush at count=3 overrides a same-cycle push and pop.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(16'h30 + i);
      @(negedge clk);
    end
    in_valid  = 1'b1;
    in_data   = 16'h3F;
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    check_eq("flush_pre_count", 32'(count), 32'd3);
    check_eq("flush_in_fire", 32'(in_fire), 32'd0);
    check_eq("flush_out_fire", 32'(out_fire), 32'd0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("flush_count", 32'(count), 32'd0);
    check_eq("flush_out_valid", 32'(out_valid), 32'd0);
    check_eq("flush_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h55;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_eq("post_flush_data", 32'(out_data), 32'h55);
    check_eq("post_flush_count", 32'(count), 32'd1);
    @(negedge clk);

    // Asynchronous reset with count=2, checked before the next rising edge.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(16'h60 + i);
      @(negedge clk);
    end
    #1;
    check_eq("arst_pre_count", 32'(count), 32'd2);
    out_ready = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    check_eq("arst_count", 32'(count), 32'd0);
    check_eq("arst_out_valid", 32'(out_valid), 32'd0);
    check_eq("arst_out_data", 32'(out_data), 32'd0);
    check_eq("arst_in_ready", 32'(in_ready), 32'd1);
    check_eq("arst_in_fire", 32'(in_fire), 32'd0);
    check_eq("arst_out_fire", 32'(out_fire), 32'd0);
    @(negedge clk);

    // First push after reset release lands on the first rising edge.
    reset     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h77;
    #1;
    check_eq("rel_in_fire", 32'(in_fire), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_eq("rel_count", 32'(count), 32'd1);
    check_eq("rel_data", 32'(out_data), 32'h77);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
